// File: rtl/clk_div_bank.sv
// Bank of CH programmable clock/tick dividers with shadowed, boundary-aligned
// divisor/high-time updates and a common phase-alignment sync.
module clk_div_bank #(
    parameter int          CH       = 4,
    parameter int          W        = 32,
    parameter int unsigned DEF_DIV  = 50000000,
    parameter int unsigned DEF_HIGH = 25000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] en,
    input  logic          sync,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_ch,
    input  logic [W-1:0]  cfg_div,
    input  logic [W-1:0]  cfg_high,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] upd_pending
);

    logic [W-1:0]  cnt_q     [CH];
    logic [W-1:0]  div_q     [CH];
    logic [W-1:0]  high_q    [CH];
    logic [W-1:0]  sh_div_q  [CH];
    logic [W-1:0]  sh_high_q [CH];
    logic [CH-1:0] pend_q;
    logic [CH-1:0] run_q;
    logic [CH-1:0] clk_q;
    logic [CH-1:0] tick_q;

    logic [W-1:0]  cnt_d     [CH];
    logic [W-1:0]  div_d     [CH];
    logic [W-1:0]  high_d    [CH];
    logic [CH-1:0] wr_sel;
    logic [CH-1:0] wrap;
    logic [CH-1:0] xfer;
    logic [CH-1:0] clk_d;
    logic [CH-1:0] tick_d;

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        return (d < W'(2)) ? W'(2) : d;
    endfunction

    always_comb begin
        wr_sel = '0;
        wrap   = '0;
        xfer   = '0;
        clk_d  = '0;
        tick_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            // Index match against i only, so cfg_ch >= CH selects nothing.
            wr_sel[i] = cfg_we && (32'(cfg_ch) == i);
            wrap[i]   = run_q[i] && en[i] && (cnt_q[i] == div_q[i] - W'(1));
            // A write in the boundary cycle wins: the transfer is deferred.
            xfer[i]   = pend_q[i] && !wr_sel[i] && (wrap[i] || !en[i] || sync);
            div_d[i]  = xfer[i] ? clamp_div(sh_div_q[i]) : div_q[i];
            high_d[i] = xfer[i] ? sh_high_q[i] : high_q[i];
            // First enabled cycle (run_q low) restarts the period at zero.
            if (!en[i] || sync || !run_q[i] || wrap[i])
                cnt_d[i] = '0;
            else
                cnt_d[i] = cnt_q[i] + W'(1);
            clk_d[i]  = en[i] && (cnt_d[i] < high_d[i]);
            tick_d[i] = en[i] && (cnt_d[i] == div_d[i] - W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CH; i++) begin
                cnt_q[i]     <= '0;
                div_q[i]     <= W'(DEF_DIV);
                high_q[i]    <= W'(DEF_HIGH);
                sh_div_q[i]  <= W'(DEF_DIV);
                sh_high_q[i] <= W'(DEF_HIGH);
            end
            pend_q <= '0;
            run_q  <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                high_q[i] <= high_d[i];
                if (wr_sel[i]) begin
                    sh_div_q[i]  <= cfg_div;
                    sh_high_q[i] <= cfg_high;
                    pend_q[i]    <= 1'b1;
                end else if (xfer[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            run_q  <= en;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, shadowed updates, clamps,
// write-on-boundary, enable gating, sync, ignored channel index and async reset.
module tb_clk_div_bank;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          sync;
    logic          cfg_we;
    logic [3:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic [W-1:0]  cfg_high;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] upd_pending;

    int n_tests = 0;
    int n_fail  = 0;
    int k;

    clk_div_bank #(
        .CH       (CH),
        .W        (W),
        .DEF_DIV  (10),
        .DEF_HIGH (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .clk_out     (clk_out),
        .tick        (tick),
        .upd_pending (upd_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) cyc();
    endtask

    // Present a config write for exactly one edge.
    task automatic wr(input logic [3:0] ch, input logic [W-1:0] d, input logic [W-1:0] h);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = d;
        cfg_high = h;
        cyc();
        cfg_we   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 4'hF;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
        k        = -100;
        repeat (2) @(negedge clk);
        check("rst_clk", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_pend", 32'(upd_pending), 0);

        // Defaults: 5 high, 5 low, tick on the last low cycle.
        reset = 1'b0;
        k = -1;
        cyc();
        for (int j = 0; j < 20; j++) begin
            check("def_clk", 32'(clk_out), (k % 10 < 5) ? 32'hF : 32'h0);
            check("def_tick", 32'(tick), (k % 10 == 9) ? 32'hF : 32'h0);
            cyc();
        end

        // Mid-period write on ch2 waits for the boundary.
        run_to(23);
        wr(2, 4, 1);
        check("upd_pend_set", 32'(upd_pending), 32'h4);
        run_to(29);
        check("upd_pend_hold", 32'(upd_pending), 32'h4);
        cyc();
        check("upd_pend_clr", 32'(upd_pending), 0);
        while (k <= 33) begin
            check("ch2_clk", 32'(clk_out[2]), ((k - 30) % 4 == 0) ? 1 : 0);
            check("ch2_tick", 32'(tick[2]), ((k - 30) % 4 == 3) ? 1 : 0);
            check("ch0_clk", 32'(clk_out[0]), (k % 10 < 5) ? 1 : 0);
            check("ch0_tick", 32'(tick[0]), 0);
            cyc();
        end

        // Clamps: ch3 div 0 -> 2, ch0 high 0, ch1 high >= div.
        wr(3, 0, 1);
        wr(0, 3, 0);
        wr(1, 6, 9);
        check("clamp_pend", 32'(upd_pending), 32'hB);
        run_to(40);
        check("clamp_pend_clr", 32'(upd_pending), 0);
        while (k <= 43) begin
            check("ch0_lo", 32'(clk_out[0]), 0);
            check("ch0_tick3", 32'(tick[0]), ((k - 40) % 3 == 2) ? 1 : 0);
            check("ch1_hi", 32'(clk_out[1]), 1);
            check("ch1_tick6", 32'(tick[1]), ((k - 40) % 6 == 5) ? 1 : 0);
            check("ch3_clk2", 32'(clk_out[3]), ((k - 40) % 2 == 0) ? 1 : 0);
            check("ch3_tick2", 32'(tick[3]), ((k - 40) % 2 == 1) ? 1 : 0);
            cyc();
        end

        // Write landing on the tick edge defers the transfer a full period.
        wr(1, 8, 2);
        check("tickcyc_tick", 32'(tick[1]), 1);
        check("tickcyc_pend", 32'(upd_pending[1]), 1);
        wr(1, 5, 3);
        check("wwin_pend", 32'(upd_pending[1]), 1);
        check("wwin_clk", 32'(clk_out[1]), 1);
        check("wwin_tick", 32'(tick[1]), 0);
        run_to(51);
        check("wwin_tick_old", 32'(tick[1]), 1);
        check("wwin_pend_old", 32'(upd_pending[1]), 1);
        cyc();
        check("wwin_pend_clr", 32'(upd_pending[1]), 0);
        while (k <= 61) begin
            check("ch1_d5_clk", 32'(clk_out[1]), ((k - 52) % 5 < 3) ? 1 : 0);
            check("ch1_d5_tick", 32'(tick[1]), ((k - 52) % 5 == 4) ? 1 : 0);
            cyc();
        end

        // Disable ch1 mid-high with a shadow pending, then re-enable.
        wr(1, 4, 2);
        check("dis_pre_clk", 32'(clk_out[1]), 1);
        en = 4'b1101;
        cyc();
        check("dis_clk", 32'(clk_out[1]), 0);
        check("dis_tick", 32'(tick[1]), 0);
        check("dis_pend", 32'(upd_pending[1]), 0);
        cyc();
        check("dis_clk2", 32'(clk_out[1]), 0);
        en = 4'hF;
        cyc();
        while (k <= 72) begin
            check("reen_clk", 32'(clk_out[1]), ((k - 66) % 4 < 2) ? 1 : 0);
            check("reen_tick", 32'(tick[1]), ((k - 66) % 4 == 3) ? 1 : 0);
            cyc();
        end

        // Sync zeroes all counters and applies ch0's pending shadow.
        wr(0, 5, 2);
        check("sync_pre_pend", 32'(upd_pending), 32'h1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync_clk", 32'(clk_out), 32'hF);
        check("sync_tick", 32'(tick), 0);
        check("sync_pend", 32'(upd_pending), 0);
        cyc();
        check("sync1_clk", 32'(clk_out), 32'h3);
        check("sync1_tick", 32'(tick), 32'h8);

        // Out-of-range channel index changes nothing.
        wr(7, 3, 3);
        check("ch7_pend", 32'(upd_pending), 0);
        check("ch7_clk", 32'(clk_out), 32'h8);
        check("ch7_tick", 32'(tick), 0);
        cyc();
        check("ch7_clk2", 32'(clk_out), 32'h0);
        check("ch7_tick2", 32'(tick), 32'hE);

        // Async reset mid-period, discarding a pending shadow.
        run_to(79);
        wr(2, 7, 7);
        check("prerst_pend", 32'(upd_pending), 32'h4);
        check("prerst_clk", 32'(clk_out), 32'h3);
        reset = 1'b1;
        #2;
        check("arst_clk", 32'(clk_out), 0);
        check("arst_tick", 32'(tick), 0);
        check("arst_pend", 32'(upd_pending), 0);
        @(negedge clk);
        reset = 1'b0;
        k = -1;
        cyc();
        for (int j = 0; j < 10; j++) begin
            check("post_clk", 32'(clk_out), (k % 10 < 5) ? 32'hF : 32'h0);
            check("post_tick", 32'(tick), (k % 10 == 9) ? 32'hF : 32'h0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
